// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared definitions for the instruction-fetch stage
package if_fetch_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 2;

    localparam logic STOP     = 1'b1;
    localparam logic CONTINUE = 1'b0;
    localparam logic JUMP     = 1'b1;
    localparam logic STAY     = 1'b0;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_byte_asm.sv
// rtl/if_byte_asm.sv - little-endian 4-byte instruction assembly register
module if_byte_asm
    import if_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [CNT_W-1:0]  idx_i,
    input  logic [7:0]        byte_i,
    output logic [INST_W-1:0] word_o
);

    logic [INST_W-1:0] word_q, word_d;

    always_comb begin
        word_d = word_q;
        if (clr_i) begin
            word_d = '0;
        end else if (en_i) begin
            word_d[{idx_i, 3'b000} +: 8] = byte_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch over an 8-bit memory port, four byte reads per word
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jpc_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    input  logic [7:0]        mem_data_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              stall_req_o
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic              asm_clr, asm_en;
    logic              jump_take;
    logic [INST_W-1:0] asm_word;

    // A redirect under stall is dropped; decode re-presents it later.
    assign jump_take = (jump_i == JUMP) && (stall_i == CONTINUE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        k_d          = k_q;
        asm_clr      = 1'b0;
        asm_en       = 1'b0;
        mem_req_o    = 1'b0;
        inst_valid_o = 1'b0;
        stall_req_o  = 1'b0;

        if (jump_take) begin
            pc_d    = jpc_i & ~32'h0000_0003;
            k_d     = '0;
            state_d = FETCH;
            asm_clr = 1'b1;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (mem_ready_i) begin
                        asm_en = 1'b1;
                        k_d    = k_q + 2'd1;
                        if (k_q == 2'd3) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (stall_i == CONTINUE) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end

        if (!rst) begin
            mem_req_o    = (state_q == FETCH);
            stall_req_o  = (state_q == FETCH);
            inst_valid_o = (state_q == HOLD) && (jump_i != JUMP);
        end
    end

    if_byte_asm u_asm (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (asm_clr),
        .en_i   (asm_en),
        .idx_i  (k_q),
        .byte_i (mem_data_i),
        .word_o (asm_word)
    );

    assign mem_addr_o = rst ? '0 : pc_q + {{(ADDR_W-CNT_W){1'b0}}, k_q};
    assign pc_o       = rst ? '0 : pc_q;
    assign inst_o     = rst ? '0 : asm_word;

endmodule
